// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch (I), data (D) and RAM-side buses around the RAM port arbiter.
// slave  : the arbiter (takes I/D requests, drives the RAM port, returns ready/rdata, busy).
// master : the surroundings (CPU fetch/data requesters and the RAM instance).
interface ram_port_arbiter_if;
  // Fetch requester
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  // Data requester
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic [31:0] d_rdata;
  // RAM port (combinational read, synchronous write)
  logic        ram_we;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  // Status
  logic        busy;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, ram_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, ram_we, ram_wstrb, ram_addr, ram_wdata, busy
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, ram_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, ram_we, ram_wstrb, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the fetch (I) and data (D) buses; IDLE -> ACCESS -> RESP.
// Latency: request seen at an IDLE edge -> ready pulse two cycles later; one access per 3 cycles.
// Backpressure: a requester holds valid until its one-cycle ready; the loser waits pending.
// Ports: clk, resetn (async active-low), bus (ram_port_arbiter_if.slave: I/D handshakes, RAM port, busy).
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants under contention; default is D-over-I priority.
module ram_port_arbiter #(
  parameter int unsigned RAM_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  ram_port_arbiter_if.slave     bus
);

  localparam logic [31:0] LP_WORDS = 32'(RAM_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_win_d;      // winner of the transaction in flight: 1 = D, 0 = I
  logic        r_last_d;     // last granted requester, kept in both builds
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [3:0]  r_ram_wstrb;
  logic        r_ram_we;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;

  logic        w_any_vld;
  logic        w_grant_d;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wstrb;
  logic        w_sel_in_range;
  logic        w_cur_in_range;
  logic [31:0] w_rd_val;

  assign w_any_vld = bus.i_valid | bus.d_valid;

`ifdef ARB_ROUND_ROBIN_EN
  // Under contention the requester that did not win last time gets the port.
  assign w_grant_d = (bus.i_valid && bus.d_valid) ? ~r_last_d : bus.d_valid;
`else
  // Fixed priority: any pending D request beats I.
  assign w_grant_d = bus.d_valid;
`endif

  // Fetches never write, so they latch a zero strobe.
  assign w_sel_addr     = w_grant_d ? bus.d_addr  : bus.i_addr;
  assign w_sel_wdata    = w_grant_d ? bus.d_wdata : 32'h0;
  assign w_sel_wstrb    = w_grant_d ? bus.d_wstrb : 4'b0000;
  assign w_sel_in_range = ({2'b00, w_sel_addr[31:2]} < LP_WORDS);
  assign w_cur_in_range = ({2'b00, r_ram_addr[31:2]} < LP_WORDS);
  assign w_rd_val       = w_cur_in_range ? bus.ram_rdata : 32'h0;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_vld) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath. ram_we is set on entry to ACCESS and cleared on leaving it, so it is high for
  // exactly the ACCESS cycle; an async reset during ACCESS drops it before the write edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_win_d     <= 1'b0;
      r_last_d    <= 1'b0;
      r_ram_addr  <= 32'h0;
      r_ram_wdata <= 32'h0;
      r_ram_wstrb <= 4'b0000;
      r_ram_we    <= 1'b0;
      r_i_rdata   <= 32'h0;
      r_d_rdata   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_vld) begin
            r_win_d     <= w_grant_d;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
            r_ram_wstrb <= w_sel_wstrb;
            r_ram_we    <= (w_sel_wstrb != 4'b0000) && w_sel_in_range;
          end
        end
        ACCESS: begin
          r_ram_we    <= 1'b0;
          r_ram_wstrb <= 4'b0000;
          if (r_ram_wstrb == 4'b0000) begin
            if (r_win_d) r_d_rdata <= w_rd_val;
            else         r_i_rdata <= w_rd_val;
          end else if (r_win_d) begin
            r_d_rdata <= 32'h0;  // write response carries no data
          end
        end
        RESP: begin
          r_last_d <= r_win_d;
        end
        default: ;
      endcase
    end
  end

  // Ready is qualified by the requester's valid so a withdrawn request gets no pulse.
  assign bus.i_ready   = (r_state == RESP) && !r_win_d && bus.i_valid;
  assign bus.d_ready   = (r_state == RESP) &&  r_win_d && bus.d_valid;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_wstrb = r_ram_wstrb;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.busy      = (r_state != IDLE);

endmodule
